// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 memory blocks: default NOP, load/run state and index width helper.
package rv32_mem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 storage with one write port and one registered read port; no reset so it can map to block RAM.
module imem_array
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: streaming load port in LOAD, registered fetch port with
// misalign/range faults in RUN. Slots at or above prog_len read back as NOP.
module imem_loadable
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = rv32_mem_pkg::NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [31:0]            ld_data,
  input  logic                   ld_last,
  output logic                   ld_err,
  output logic [idx_w(DEPTH):0]  prog_len,
  input  logic                   if_req,
  output logic                   if_ready,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic                   if_fault
);

  localparam int unsigned IW = idx_w(DEPTH);

  state_e          state_q, state_d;
  logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW:0]     prog_len_q, prog_len_d;
  logic            ld_err_q, ld_err_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic            rsp_nop_q, rsp_nop_d;

  logic            ld_fire, if_fire, at_end;
  logic            misalign, out_of_range, unloaded;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]     rd_data;

  // Full-width index compares: high address bits alias to a fault, never to a low slot.
  assign word_idx     = if_addr >> 2;
  assign misalign     = |if_addr[1:0];
  assign out_of_range = word_idx >= ADDR_W'(DEPTH);
  assign unloaded     = word_idx >= ADDR_W'(prog_len_q);

  assign ld_fire = ld_valid && (state_q == LOAD) && !ld_start;
  assign if_fire = if_req && (state_q == RUN);
  assign at_end  = wr_ptr_q == IW'(DEPTH - 1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    ld_err_d    = ld_err_q;
    rsp_vld_d   = if_fire;
    rsp_fault_d = rsp_fault_q;
    rsp_nop_d   = rsp_nop_q;

    if (ld_start) begin
      state_d    = LOAD;
      wr_ptr_d   = '0;
      prog_len_d = '0;
      ld_err_d   = 1'b0;
    end else if (ld_fire) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      prog_len_d = prog_len_q + 1'b1;
      if (ld_last || at_end) state_d = RUN;
      if (!ld_last && at_end) ld_err_d = 1'b1;
    end

    // Response flags sample the pre-restart prog_len, so a fetch racing ld_start sees old contents.
    if (if_fire) begin
      rsp_fault_d = misalign || out_of_range;
      rsp_nop_d   = misalign || out_of_range || unloaded;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      ld_err_q    <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_nop_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      ld_err_q    <= ld_err_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_nop_q   <= rsp_nop_d;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (wr_ptr_q),
    .wdata (ld_data),
    .re    (if_fire),
    .raddr (word_idx[IW-1:0]),
    .rdata (rd_data)
  );

  assign ld_ready = (state_q == LOAD);
  assign if_ready = (state_q == RUN);
  assign ld_err   = ld_err_q;
  assign prog_len = prog_len_q;
  assign if_valid = rsp_vld_q;
  assign if_fault = rsp_fault_q;
  assign if_instr = rsp_nop_q ? NOP_WORD : rd_data;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: fetch vector table plus load/restart/overflow/reset sequences, scoreboarded.
module tb_imem_loadable;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, ld_start, ld_valid, ld_last, if_req;
  logic [31:0] ld_data, if_addr;
  logic        ld_ready, ld_err, if_ready, if_valid, if_fault;
  logic [6:0]  prog_len;
  logic [31:0] if_instr;

  imem_loadable dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .ld_err(ld_err), .prog_len(prog_len),
    .if_req(if_req), .if_ready(if_ready), .if_addr(if_addr), .if_valid(if_valid),
    .if_instr(if_instr), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] instr; logic fault; } vec_t;
  typedef struct { logic [31:0] instr; logic fault; } rsp_t;

  rsp_t        sb[$];
  logic [31:0] model_mem [64];
  int          model_len;
  logic [31:0] wbuf[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for a fetch against the bench's own copy of the loaded program.
  function automatic rsp_t model_fetch(input logic [31:0] a);
    rsp_t r;
    logic [31:0] idx;
    idx = a >> 2;
    if (a[1:0] != 2'b00 || idx >= 32'd64) begin r.instr = NOP; r.fault = 1'b1; end
    else if (idx >= 32'(model_len))       begin r.instr = NOP; r.fault = 1'b0; end
    else                                  begin r.instr = model_mem[idx]; r.fault = 1'b0; end
    return r;
  endfunction

  task automatic fetch(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
    sb.push_back(model_fetch(a));
    tick();
    if_req = 1'b0;
  endtask

  task automatic load(input bit use_last);
    for (int i = 0; i < wbuf.size(); i++) begin
      chk("ld_ready_beat", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_data  = wbuf[i];
      ld_last  = use_last && (i == wbuf.size() - 1);
      model_mem[i] = wbuf[i];
      tick();
    end
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    model_len = wbuf.size();
  endtask

  task automatic restart();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (if_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_instr", if_instr, e.instr);
        chk("rsp_fault", 32'(if_fault), 32'(e.fault));
      end
    end
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h00C5_8533, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h40B5_0533, 1'b0};
    vecs[3] = '{32'h0000_000C, NOP,           1'b0};
    vecs[4] = '{32'h0000_0006, NOP,           1'b1};
    vecs[5] = '{32'h0000_0100, NOP,           1'b1};
    vecs[6] = '{32'h8000_0000, NOP,           1'b1};

    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; if_req = 1'b0;
    ld_data = '0; if_addr = '0; model_len = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_ld_err",   32'(ld_err),   32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr,      NOP);
    chk("rst_if_fault", 32'(if_fault), 32'd0);

    // 3-word program, then the fetch table back-to-back
    wbuf = '{32'h0000_0013, 32'h00C5_8533, 32'h40B5_0533};
    load(1'b1);
    chk("l3_prog_len", 32'(prog_len), 32'd3);
    chk("l3_if_ready", 32'(if_ready), 32'd1);
    chk("l3_ld_ready", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 7; i++) begin
      if_req  = 1'b1;
      if_addr = vecs[i].addr;
      sb.push_back('{vecs[i].instr, vecs[i].fault});
      tick();
    end
    if_req = 1'b0;
    tick();
    chk("idle_valid",  32'(if_valid), 32'd0);
    chk("hold_fault",  32'(if_fault), 32'd1);
    chk("hold_instr",  if_instr,      NOP);

    // Fetch racing ld_start still answers with the old word
    if_req = 1'b1; if_addr = 32'h4; ld_start = 1'b1;
    sb.push_back('{32'h00C5_8533, 1'b0});
    tick();
    if_req = 1'b0; ld_start = 1'b0;
    chk("race_valid",    32'(if_valid), 32'd1);
    chk("race_if_ready", 32'(if_ready), 32'd0);
    chk("race_prog_len", 32'(prog_len), 32'd0);
    chk("race_ld_err",   32'(ld_err),   32'd0);

    // Fetch in LOAD is ignored; beats then reset mid-load
    if_req = 1'b1; if_addr = 32'h0;
    tick();
    if_req = 1'b0;
    tick();
    chk("load_no_rsp", 32'(if_valid), 32'd0);
    wbuf = '{32'hDEAD_0000, 32'hDEAD_0001};
    load(1'b0);
    chk("mid_prog_len", 32'(prog_len), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_len = 0;
    chk("mid_rst_len",   32'(prog_len), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd1);
    wbuf = '{32'h0010_0093, 32'h0020_0113};
    load(1'b1);
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    tick();

    // Reload shorter program: stale slot 1 must read as NOP
    restart();
    wbuf = '{32'h0030_0193};
    load(1'b1);
    chk("reload_len", 32'(prog_len), 32'd1);
    fetch(32'h0); fetch(32'h4);
    tick();

    // Overflow: 64 beats, no ld_last
    restart();
    wbuf.delete();
    for (int i = 0; i < 64; i++) wbuf.push_back($urandom());
    load(1'b0);
    chk("ovf_if_ready", 32'(if_ready), 32'd1);
    chk("ovf_ld_ready", 32'(ld_ready), 32'd0);
    chk("ovf_ld_err",   32'(ld_err),   32'd1);
    chk("ovf_prog_len", 32'(prog_len), 32'd64);
    fetch(32'hFC); fetch(32'h0); fetch(32'h100);
    ld_valid = 1'b1; ld_data = 32'hBAD0_BAD0;
    tick();
    ld_valid = 1'b0;
    chk("run_beat_len", 32'(prog_len), 32'd64);
    fetch(32'h0);
    tick();

    // Fetch accepted in the reset cycle gets no response
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
    tick();
    rst = 1'b0; if_req = 1'b0;
    chk("rstf_valid", 32'(if_valid), 32'd0);
    chk("rstf_instr", if_instr,      NOP);
    tick();
    chk("rstf_valid2", 32'(if_valid), 32'd0);
    chk("rstf_ld_err", 32'(ld_err),   32'd0);

    tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, byte-addressed instruction memory for the RISCV32 cores.
- Its contents are loaded at run time through a streaming load port instead of being hard-coded.
- Provides a registered fetch port with one-cycle latency, plus fault reporting for misaligned and out-of-range fetches.
- Sits between the PC/fetch stage and a testbench or boot loader. Replaces fixed-contents instruction ROMs in single-cycle and pipelined cores.

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two, minimum 2.
- ADDR_W, 32, width of the fetch byte address.
- NOP_WORD, 32'h00000013, word returned for unloaded or faulting fetches (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_start  in  1  pulse: abandon current program, re-enter LOAD.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted; high only in LOAD.
- ld_data  in  32  instruction word for the next sequential slot.
- ld_last  in  1  marks the final word of the program.
- ld_err  out  1  sticky flag: program exceeded DEPTH words without ld_last.
- prog_len  out  clog2(DEPTH)+1  number of words loaded.
- if_req  in  1  fetch request.
- if_ready  out  1  fetch accepted; high only in RUN.
- if_addr  in  ADDR_W  fetch byte address.
- if_valid  out  1  fetch response valid; one cycle after acceptance.
- if_instr  out  32  fetched word.
- if_fault  out  1  response is a fault; if_instr = NOP_WORD.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=LOAD, wr_ptr=0, prog_len=0, ld_err=0.
  - if_valid=0, if_instr=NOP_WORD, if_fault=0.
  - Array contents are not cleared; locations at or above prog_len are masked instead.
  - Reset mid-load or mid-fetch discards everything in flight; no response is issued for a fetch accepted in the reset cycle.
- States:
  - LOAD: ld_ready=1, if_ready=0.
  - RUN: ld_ready=0, if_ready=1.
- LOAD, per accepted beat (ld_valid & ld_ready):
  - mem[wr_ptr] <= ld_data; wr_ptr++; prog_len++.
  - With ld_last=1: go to RUN next cycle.
  - If wr_ptr==DEPTH-1 without ld_last: word is written, prog_len=DEPTH, go to RUN, ld_err<=1.
  - No wrap-around: a later slot is never overwritten.
- LOAD, no beat: hold state. ld_start in LOAD restarts the load: wr_ptr=0, prog_len=0, ld_err=0; a beat in the same cycle is dropped.
- RUN, fetch acceptance (if_req & if_ready): the next cycle gives if_valid=1 and:
  - if_addr[1:0]!=0: if_fault=1, if_instr=NOP_WORD.
  - word index (if_addr>>2) >= DEPTH: if_fault=1, if_instr=NOP_WORD.
  - word index >= prog_len: if_fault=0, if_instr=NOP_WORD (unloaded slot executes as NOP).
  - otherwise: if_fault=0, if_instr=mem[index].
- Fetch responses: back-to-back every cycle, no bubbles. if_valid=0 in any cycle following no acceptance; if_instr/if_fault hold their previous values then.
- ld_start in RUN: next state LOAD, wr_ptr=0, prog_len=0, ld_err=0.
  - A fetch accepted in the same cycle still responds next cycle with the old contents.
- Index compare uses the full address. Upper address bits are never silently truncated; aliasing is a fault.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - NOP_WORD constant.
  - state enum {LOAD, RUN}.
  - function idx_w(depth)=clog2(depth).
- One natural sub-module, imem_array: single write port and single registered read port, DEPTH x 32. It holds the storage only, so it can later map onto block RAM.
- FSM, pointers and fault logic stay in the top module.

Test Plan:
- Reset; load 3 words {00000013, 00C58533, 40B50533} with ld_last on the third -> prog_len=3, RUN; fetch 0x0/0x4/0x8 back-to-back -> those words on consecutive cycles, if_fault=0.
- After the 3-word load, fetch 0xC -> if_instr=00000013, if_fault=0; fetch 0x6 -> if_fault=1; fetch 0x100 (DEPTH=64) -> if_fault=1, if_instr=00000013.
- Stream 64 beats with no ld_last -> RUN after the 64th, ld_err=1, prog_len=64; fetch 0xFC returns the 64th word; ld_ready=0 afterwards.
- In RUN, assert if_req(0x4) and ld_start together -> next cycle if_valid=1 with the old word, state LOAD, if_ready=0, prog_len=0, ld_err=0.
- In LOAD, assert if_req -> if_valid stays 0; ld_valid while ld_ready=1, then rst mid-load -> prog_len=0, then a new load starts at slot 0.
- Load 2 words, RUN, ld_start, load 1 new word -> fetch 0x0 returns the new word; fetch 0x4 returns NOP_WORD (stale slot masked).
